// File: rtl/tcdm_banked_responder_pkg.sv
// Shared types and constants for the banked TCDM responder.
package tcdm_responder_package;

  localparam int unsigned TCDM_DW = 32;
  localparam int unsigned TCDM_BW = 4;

  // One TCDM request as seen by a single slave port.
  typedef struct packed {
    logic [TCDM_DW-1:0] add;
    logic               wen;
    logic [TCDM_BW-1:0] be;
    logic [TCDM_DW-1:0] data;
  } tcdm_req_t;

  // One TCDM response as driven back to a single slave port.
  typedef struct packed {
    logic [TCDM_DW-1:0] r_data;
    logic               r_valid;
  } tcdm_rsp_t;

  // Index width for a count of n items; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_banked_responder_if.sv
// MP-port TCDM bus between accelerator masters and the banked responder.
//
// Handshake: a master raises tcdm_req with add/wen/be/data and holds all of
// them stable until it sees tcdm_gnt=1 in the same cycle; the transaction is
// accepted on the rising edge where req=1 and gnt=1. Exactly one cycle later
// tcdm_r_valid pulses for that port (reads carry data, writes carry zero).
// There is no backpressure on the response channel.
interface tcdm_banked_responder_if #(
  parameter int unsigned MP = 4
);
  import tcdm_responder_package::*;

  logic [MP-1:0]              tcdm_req;
  logic [MP-1:0]              tcdm_gnt;
  logic [MP-1:0][TCDM_DW-1:0] tcdm_add;
  logic [MP-1:0]              tcdm_wen;
  logic [MP-1:0][TCDM_BW-1:0] tcdm_be;
  logic [MP-1:0][TCDM_DW-1:0] tcdm_data;
  logic [MP-1:0][TCDM_DW-1:0] tcdm_r_data;
  logic [MP-1:0]              tcdm_r_valid;

  modport master (
    output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    input  tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );

  modport slave (
    input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    output tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );

endinterface

// File: rtl/tcdm_banked_responder_arbiter.sv
// Round-robin arbiter for one bank: combinational one-hot grant, pointer
// advances past the winner whenever a grant is issued.
module tcdm_rr_arbiter
  import tcdm_responder_package::*;
#(
  parameter int unsigned MP = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [MP-1:0] req_i,
  output logic [MP-1:0] gnt_o
);

  localparam int unsigned PW = idx_w(MP);

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  // Pick the first requester at or after the pointer, wrapping modulo MP.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MP; i++) begin
      idx = PW'((rr_q + i) % MP);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win        = idx;
      end
    end
    rr_d = found ? PW'((win + 1) % MP) : rr_q;
  end

  // Pointer register; an idle bank keeps its pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/tcdm_banked_responder.sv
// Word-interleaved banked SRAM behind MP TCDM slave ports. Same-cycle grant
// per bank via round-robin, fixed one-cycle response for reads and writes.
module tcdm_banked_responder
  import tcdm_responder_package::*;
#(
  parameter int unsigned MP        = 4,
  parameter int unsigned NB_BANKS  = 8,
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tcdm_banked_responder_if.slave  tcdm
);

  localparam int unsigned ROWS = MEM_WORDS / NB_BANKS;
  localparam int unsigned BIW  = idx_w(NB_BANKS);
  localparam int unsigned RIW  = idx_w(ROWS);
  localparam int unsigned WIW  = idx_w(MEM_WORDS);

  tcdm_req_t [MP-1:0]                      port_req;
  logic      [MP-1:0][BIW-1:0]             bank_sel;
  logic      [MP-1:0][RIW-1:0]             row_sel;
  logic      [31:0]                        word;
  logic                                    unused_addr_bits;
  logic      [NB_BANKS-1:0][MP-1:0]        bank_gnt;
  logic      [NB_BANKS-1:0][TCDM_DW-1:0]   bank_rd;
  logic      [MP-1:0]                      gnt;
  tcdm_rsp_t [MP-1:0]                      rsp_q, rsp_d;

  // Bundle each port and decode word address into bank and row; the byte
  // offset and anything above MEM_WORDS are dropped (silent wrap).
  always_comb begin
    word             = '0;
    unused_addr_bits = 1'b0;
    for (int unsigned p = 0; p < MP; p++) begin
      port_req[p] = '{add:  tcdm.tcdm_add[p],
                      wen:  tcdm.tcdm_wen[p],
                      be:   tcdm.tcdm_be[p],
                      data: tcdm.tcdm_data[p]};
      word        = 32'(port_req[p].add[2 +: WIW]);
      bank_sel[p] = BIW'(word % NB_BANKS);
      row_sel[p]  = RIW'(word / NB_BANKS);
      unused_addr_bits = unused_addr_bits ^ (^port_req[p].add);
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [MP-1:0]      req_b;
    logic [MP-1:0]      gnt_b;
    logic               sel_wen;
    logic [TCDM_BW-1:0] sel_be;
    logic [TCDM_DW-1:0] sel_data;
    logic [RIW-1:0]     sel_row;
    logic               sel_vld;
    logic [TCDM_DW-1:0] mem_q [ROWS];

    // Requests aimed at this bank; reset suppresses every grant.
    always_comb begin
      req_b = '0;
      for (int unsigned p = 0; p < MP; p++)
        req_b[p] = tcdm.tcdm_req[p] && (bank_sel[p] == BIW'(b)) && !rst_i;
    end

    tcdm_rr_arbiter #(.MP(MP)) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (req_b),
      .gnt_o (gnt_b)
    );

    // Route the single granted port's command into the bank.
    always_comb begin
      sel_wen  = 1'b1;
      sel_be   = '0;
      sel_data = '0;
      sel_row  = '0;
      sel_vld  = 1'b0;
      for (int unsigned p = 0; p < MP; p++) begin
        if (gnt_b[p]) begin
          sel_wen  = port_req[p].wen;
          sel_be   = port_req[p].be;
          sel_data = port_req[p].data;
          sel_row  = row_sel[p];
          sel_vld  = 1'b1;
        end
      end
    end

    // Byte-masked write on the accepting edge; contents are never reset.
    always_ff @(posedge clk_i) begin
      if (sel_vld && !sel_wen) begin
        for (int i = 0; i < int'(TCDM_BW); i++)
          if (sel_be[i]) mem_q[sel_row][8*i +: 8] <= sel_data[8*i +: 8];
      end
    end

    assign bank_gnt[b] = gnt_b;
    assign bank_rd[b]  = mem_q[sel_row];
  end

  // Merge per-bank grants and form next responses; r_data holds when idle.
  always_comb begin
    gnt   = '0;
    rsp_d = rsp_q;
    for (int unsigned b = 0; b < NB_BANKS; b++) gnt = gnt | bank_gnt[b];
    for (int unsigned p = 0; p < MP; p++) begin
      rsp_d[p].r_valid = gnt[p];
      if (gnt[p]) rsp_d[p].r_data = port_req[p].wen ? bank_rd[bank_sel[p]] : '0;
    end
  end

  // Response register; reset drops anything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  // Drive the bus outputs.
  always_comb begin
    tcdm.tcdm_gnt = gnt;
    for (int unsigned p = 0; p < MP; p++) begin
      tcdm.tcdm_r_data[p]  = rsp_q[p].r_data;
      tcdm.tcdm_r_valid[p] = rsp_q[p].r_valid;
    end
  end

endmodule

// File: tb/tb_tcdm_banked_responder.sv
// Directed bench for tcdm_banked_responder (MP=4, 8 banks, 4096 words).
module tb_tcdm_banked_responder;
  import tcdm_responder_package::*;

  localparam int unsigned MP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  tcdm_banked_responder_if #(.MP(MP)) tcdm();

  tcdm_banked_responder #(.MP(MP), .NB_BANKS(8), .MEM_WORDS(4096)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .tcdm  (tcdm)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [1:0] p, input logic req, input logic [31:0] add,
                       input logic wen, input logic [3:0] be, input logic [31:0] data);
    tcdm.tcdm_req[p]  = req;
    tcdm.tcdm_add[p]  = add;
    tcdm.tcdm_wen[p]  = wen;
    tcdm.tcdm_be[p]   = be;
    tcdm.tcdm_data[p] = data;
  endtask

  task automatic idle_all();
    tcdm.tcdm_req  = '0;
    tcdm.tcdm_add  = '0;
    tcdm.tcdm_wen  = '1;
    tcdm.tcdm_be   = '0;
    tcdm.tcdm_data = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held 3 cycles with every port requesting bank 0.
    idle_all();
    for (int k = 0; k < 4; k++) drive(2'(k), 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rst_gnt_c%0d", c), 32'(tcdm.tcdm_gnt), 32'h0);
      check($sformatf("rst_rvalid_c%0d", c), 32'(tcdm.tcdm_r_valid), 32'h0);
      for (int k = 0; k < 4; k++)
        check($sformatf("rst_rdata%0d_c%0d", k, c), tcdm.tcdm_r_data[k], 32'h0);
    end
    rst = 1'b0;
    settle();
    check("release_gnt", 32'(tcdm.tcdm_gnt), 32'h1);
    idle_all();
    tick();
    check("release_no_accept", 32'(tcdm.tcdm_r_valid), 32'h0);

    // Conflict on bank 0: four writes, held until granted.
    for (int k = 0; k < 4; k++)
      drive(2'(k), 1'b1, 32'(k) * 32'h20, 1'b0, 4'hF, 32'hC0DE_0000 + 32'(k));
    settle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cfl_w_gnt%0d", k), 32'(tcdm.tcdm_gnt), 32'(1 << k));
      tick();
      check($sformatf("cfl_w_rvalid%0d", k), 32'(tcdm.tcdm_r_valid), 32'(1 << k));
      check($sformatf("cfl_w_rdata%0d", k), tcdm.tcdm_r_data[k], 32'h0);
      tcdm.tcdm_req[k] = 1'b0;
      settle();
    end
    check("cfl_w_gnt_done", 32'(tcdm.tcdm_gnt), 32'h0);
    tick();
    check("cfl_w_rvalid_done", 32'(tcdm.tcdm_r_valid), 32'h0);

    // Repeat run as reads: pointer wrapped to 0, order restarts at port 0.
    for (int k = 0; k < 4; k++) begin
      drive(2'(k), 1'b1, 32'(k) * 32'h20, 1'b1, 4'h0, 32'h0);
      exp_q.push_back(32'hC0DE_0000 + 32'(k));
    end
    settle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cfl_r_gnt%0d", k), 32'(tcdm.tcdm_gnt), 32'(1 << k));
      tick();
      check($sformatf("cfl_r_rvalid%0d", k), 32'(tcdm.tcdm_r_valid), 32'(1 << k));
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check($sformatf("cfl_r_rdata%0d", k), tcdm.tcdm_r_data[k], exp_v);
      tcdm.tcdm_req[k] = 1'b0;
      settle();
    end
    idle_all();

    // Single port: write, idle, read.
    drive(2'd0, 1'b1, 32'h100, 1'b0, 4'hF, 32'hDEAD_BEEF);
    settle();
    check("sp_w_gnt", 32'(tcdm.tcdm_gnt), 32'h1);
    tick();
    check("sp_w_rvalid", 32'(tcdm.tcdm_r_valid), 32'h1);
    check("sp_w_rdata", tcdm.tcdm_r_data[0], 32'h0);
    idle_all();
    tick();
    check("sp_idle_rvalid", 32'(tcdm.tcdm_r_valid), 32'h0);
    drive(2'd0, 1'b1, 32'h100, 1'b1, 4'h0, 32'h0);
    settle();
    check("sp_r_gnt", 32'(tcdm.tcdm_gnt), 32'h1);
    tick();
    check("sp_r_rvalid", 32'(tcdm.tcdm_r_valid), 32'h1);
    check("sp_r_rdata", tcdm.tcdm_r_data[0], 32'hDEAD_BEEF);
    idle_all();
    tick();
    check("sp_hold_rvalid", 32'(tcdm.tcdm_r_valid), 32'h0);
    check("sp_hold_rdata", tcdm.tcdm_r_data[0], 32'hDEAD_BEEF);

    // Byte enables, back-to-back write/write/read on one row.
    drive(2'd0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h1122_3344);
    settle();
    tick();
    drive(2'd0, 1'b1, 32'h20, 1'b0, 4'b0101, 32'hAABB_CCDD);
    settle();
    check("be_w2_gnt", 32'(tcdm.tcdm_gnt), 32'h1);
    tick();
    check("be_w2_rvalid", 32'(tcdm.tcdm_r_valid), 32'h1);
    drive(2'd0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0);
    settle();
    tick();
    check("be_r_rvalid", 32'(tcdm.tcdm_r_valid), 32'h1);
    check("be_r_rdata", tcdm.tcdm_r_data[0], 32'h11BB_33DD);
    idle_all();

    // Parallel banks: four writes then four reads, all granted together.
    for (int k = 0; k < 4; k++)
      drive(2'(k), 1'b1, 32'(k) * 32'h4, 1'b0, 4'hF, 32'h1111_1111 * 32'(k + 1));
    settle();
    check("par_w_gnt", 32'(tcdm.tcdm_gnt), 32'hF);
    tick();
    check("par_w_rvalid", 32'(tcdm.tcdm_r_valid), 32'hF);
    for (int k = 0; k < 4; k++) drive(2'(k), 1'b1, 32'(k) * 32'h4, 1'b1, 4'h0, 32'h0);
    settle();
    check("par_r_gnt", 32'(tcdm.tcdm_gnt), 32'hF);
    tick();
    check("par_r_rvalid", 32'(tcdm.tcdm_r_valid), 32'hF);
    for (int k = 0; k < 4; k++)
      check($sformatf("par_r_rdata%0d", k), tcdm.tcdm_r_data[k], 32'h1111_1111 * 32'(k + 1));
    idle_all();

    // Address wrap: 0x4000 aliases word 0.
    drive(2'd0, 1'b1, 32'h4000, 1'b0, 4'hF, 32'h5A5A_5A5A);
    settle();
    tick();
    drive(2'd0, 1'b1, 32'h0, 1'b1, 4'h0, 32'h0);
    settle();
    tick();
    check("wrap_rvalid", 32'(tcdm.tcdm_r_valid), 32'h1);
    check("wrap_rdata", tcdm.tcdm_r_data[0], 32'h5A5A_5A5A);
    idle_all();

    // Reset asserted mid-operation kills grants and clears responses.
    drive(2'd1, 1'b1, 32'h4, 1'b1, 4'h0, 32'h0);
    settle();
    check("mid_pre_gnt", 32'(tcdm.tcdm_gnt), 32'h2);
    rst = 1'b1;
    settle();
    check("mid_rst_gnt", 32'(tcdm.tcdm_gnt), 32'h0);
    check("mid_rst_rdata0", tcdm.tcdm_r_data[0], 32'h0);
    tick();
    check("mid_rst_rvalid", 32'(tcdm.tcdm_r_valid), 32'h0);
    check("mid_rst_gnt_held", 32'(tcdm.tcdm_gnt), 32'h0);
    rst = 1'b0;
    idle_all();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
